// File: rtl/hw1_seq_checker.sv
// hw1 sequencer/checker: steps a fixed 10-vector table into hw1,
// samples O1 at the end of each dwell window and scores the run.
module hw1_seq_checker #(
  parameter int unsigned DWELL  = 5,
  parameter logic [9:0]  EXPECT = 10'b0000000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       O1,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       sel,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [9:0] capture,
  output logic [3:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] DW_LAST = 8'(DWELL - 1);
  localparam logic [3:0] IDX_LAST = 4'd9;

  state_t     state, state_n;
  logic [3:0] vec_idx, vec_n;
  logic [7:0] dwell_cnt, dw_n;
  logic [3:0] stim, stim_n;
  logic [9:0] cap_n;
  logic [3:0] err_n;
  logic       pass_n;

  // {a,b,c,sel} pattern for each table index
  function automatic logic [3:0] vec_of(input logic [3:0] idx);
    logic [3:0] v;
    case (idx)
      4'd0:    v = 4'b0000;
      4'd1:    v = 4'b1000;
      4'd2:    v = 4'b0100;
      4'd3:    v = 4'b1110;
      4'd4:    v = 4'b0010;
      4'd5:    v = 4'b1011;
      4'd6:    v = 4'b0111;
      4'd7:    v = 4'b1101;
      4'd8:    v = 4'b0001;
      4'd9:    v = 4'b1001;
      default: v = 4'b0000;
    endcase
    return v;
  endfunction

  // next-state, stimulus and scoring; abort overrides everything
  always_comb begin
    state_n = state;
    vec_n   = vec_idx;
    dw_n    = dwell_cnt;
    stim_n  = stim;
    cap_n   = capture;
    err_n   = err_cnt;
    if (abort) begin
      state_n = IDLE;
      stim_n  = 4'b0000;
    end else begin
      unique case (state)
        RUN: begin
          stim_n = vec_of(vec_idx);
          if (dwell_cnt == DW_LAST) begin
            cap_n[vec_idx] = O1;
            if (O1 != EXPECT[vec_idx])
              err_n = err_cnt + 4'd1;
            dw_n = 8'd0;
            if (vec_idx == IDX_LAST) begin
              state_n = DONE;
              stim_n  = 4'b0000;
            end else begin
              vec_n  = vec_idx + 4'd1;
              stim_n = vec_of(vec_idx + 4'd1);
            end
          end else begin
            dw_n = dwell_cnt + 8'd1;
          end
        end
        default: begin
          stim_n = 4'b0000;
          if (start) begin
            state_n = RUN;
            vec_n   = 4'd0;
            dw_n    = 8'd0;
            cap_n   = 10'd0;
            err_n   = 4'd0;
            stim_n  = vec_of(4'd0);
          end
        end
      endcase
    end
    pass_n = (state_n == DONE) && (err_n == 4'd0);
  end

  // state and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      vec_idx   <= 4'd0;
      dwell_cnt <= 8'd0;
      stim      <= 4'b0000;
      capture   <= 10'd0;
      err_cnt   <= 4'd0;
      pass      <= 1'b0;
    end else begin
      state     <= state_n;
      vec_idx   <= vec_n;
      dwell_cnt <= dw_n;
      stim      <= stim_n;
      capture   <= cap_n;
      err_cnt   <= err_n;
      pass      <= pass_n;
    end
  end

  assign {a, b, c, sel} = stim;
  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_hw1_seq_checker.sv
// Scoreboard bench for hw1_seq_checker: runs are queued with their
// expected results, a monitor checks stimulus timing and final scores.
module tb_hw1_seq_checker;

  localparam int         DW  = 5;
  localparam logic [9:0] EXP = 10'b1010010110;

  typedef struct packed {
    logic [9:0] cap;
    logic [3:0] err;
    logic       pss;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       O1;
  logic       a, b, c, sel;
  logic       busy, done, pass;
  logic [9:0] capture;
  logic [3:0] err_cnt;

  int total = 0;
  int bad = 0;
  int mode = 0;
  exp_t q[$];

  logic [3:0] tbl [10] = '{
    4'b0000, 4'b1000, 4'b0100, 4'b1110, 4'b0010,
    4'b1011, 4'b0111, 4'b1101, 4'b0001, 4'b1001
  };

  hw1_seq_checker #(.DWELL(DW), .EXPECT(EXP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .O1(O1), .a(a), .b(b), .c(c), .sel(sel),
    .busy(busy), .done(done), .pass(pass),
    .capture(capture), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // hw1 stand-in: 0, 1, expected-pattern mux, or mux with vector 3 flipped
  always_comb begin
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 10; i++)
      if ({a, b, c, sel} == tbl[i]) hit = EXP[i];
    if (mode == 3 && {a, b, c, sel} == tbl[3]) hit = ~hit;
    unique case (mode)
      0:       O1 = 1'b0;
      1:       O1 = 1'b1;
      default: O1 = hit;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // monitor: per-cycle stimulus vs table, and run results on done rise
  int  cyc = 0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done && !prev_done) begin
      chk("run_len", cyc, 10 * DW);
      if (q.size() == 0) begin
        chk("sb_empty_pop", 1, 0);
      end else begin
        e = q.pop_front();
        chk("capture", {22'd0, capture}, {22'd0, e.cap});
        chk("err_cnt", {28'd0, err_cnt}, {28'd0, e.err});
        chk("pass", {31'd0, pass}, {31'd0, e.pss});
        chk("done_stim", {28'd0, a, b, c, sel}, 0);
      end
    end
    prev_done = done;
    if (busy) begin
      if (cyc < 10 * DW)
        chk("stim", {28'd0, a, b, c, sel}, {28'd0, tbl[cyc / DW]});
      else
        chk("busy_overrun", cyc, 10 * DW - 1);
      cyc++;
    end else begin
      cyc = 0;
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic run(input int m, input exp_t e);
    mode = m;
    q.push_back(e);
    pulse_start();
    wait_done();
  endtask

  function automatic logic [31:0] all_out();
    return {13'd0, a, b, c, sel, busy, done, pass, capture, err_cnt};
  endfunction

  initial begin
    #12;
    chk("reset_outs", all_out(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1 chk("idle_outs", all_out(), 0);

    run(0, '{cap: 10'h000, err: 4'd5, pss: 1'b0});
    run(1, '{cap: 10'h3FF, err: 4'd5, pss: 1'b0});
    run(2, '{cap: EXP, err: 4'd0, pss: 1'b1});
    run(3, '{cap: 10'b1010011110, err: 4'd1, pss: 1'b0});

    // abort from DONE keeps results
    @(negedge clk) abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_done_st", {30'd0, busy, done}, 0);
    chk("abort_done_cap", {22'd0, capture}, {22'd0, 10'b1010011110});
    chk("abort_done_err", {28'd0, err_cnt}, 1);
    chk("abort_done_pass", {31'd0, pass}, 0);

    // abort during vector 4
    mode = 2;
    pulse_start();
    repeat (22) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_busy", {30'd0, busy, done}, 0);
    chk("abort_stim", {28'd0, a, b, c, sel}, 0);
    chk("abort_cap", {22'd0, capture}, {22'd0, 10'b0000000110});
    chk("abort_err", {28'd0, err_cnt}, 0);

    // start and abort together: stays idle
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    abort = 1'b0;
    chk("start_abort", {30'd0, busy, done}, 0);
    chk("start_abort_cap", {22'd0, capture}, {22'd0, 10'b0000000110});

    // reset in vector 6
    pulse_start();
    repeat (32) @(posedge clk);
    #1 chk("pre_rst_stim", {28'd0, a, b, c, sel}, {28'd0, tbl[6]});
    #1 rst_n = 1'b0;
    #1 chk("rst_mid_outs", all_out(), 0);
    @(negedge clk) rst_n = 1'b1;
    run(2, '{cap: EXP, err: 4'd0, pss: 1'b1});

    chk("sb_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
